// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared state encoding and default parameters for the hazard sequencer
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MD_BUSY = 2'd2, MD_DONE = 2'd3} state_t;
  localparam int REG_AW_DEF = 5;
  localparam int MD_TIMEOUT_DEF = 40;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: load-use compare between the DX load and the FD source registers
module pipe_hazard_ctrl_hazard_detect import pipe_hazard_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              dx_is_load,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic [REG_AW-1:0] fd_rs,
  input  logic [REG_AW-1:0] fd_rt,
  input  logic              fd_uses_rt,
  output logic              lu
);
  assign lu = dx_is_load && dx_rd != '0 && (dx_rd == fd_rs || (fd_uses_rt && dx_rd == fd_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline latches
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              dx_is_load,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic [REG_AW-1:0] fd_rs,
  input  logic [REG_AW-1:0] fd_rt,
  input  logic              fd_uses_rt,
  input  logic              x_br_taken,
  input  logic              x_md_op,
  input  logic              md_ready,
  input  logic              md_excep,
  output logic              pc_en,
  output logic              fd_en,
  output logic              dx_en,
  output logic              xm_en,
  output logic              mw_en,
  output logic              fd_clr,
  output logic              dx_clr,
  output logic              xm_clr,
  output logic              mw_clr,
  output logic              md_start,
  output logic              md_sel,
  output logic              math_excep,
  output logic [CNT_W-1:0]  stall_cycles
);
  localparam int BW = $clog2(MD_TIMEOUT + 1);
  state_t state, state_nx;
  logic [BW-1:0] busy_cnt;
  logic exc_q, to_q, lu, stall, busy_last;
  pipe_hazard_ctrl_hazard_detect #(.REG_AW(REG_AW)) u_hd (
    .dx_is_load(dx_is_load),
    .dx_rd(dx_rd),
    .fd_rs(fd_rs),
    .fd_rt(fd_rt),
    .fd_uses_rt(fd_uses_rt),
    .lu(lu)
  );
  assign busy_last = busy_cnt == BW'(MD_TIMEOUT - 1);
  always_comb begin
    {pc_en, fd_en, dx_en, xm_en, mw_en} = '0;
    {fd_clr, dx_clr, xm_clr, mw_clr} = '0;
    {md_start, md_sel, math_excep} = '0;
    stall = 1'b0;
    state_nx = state;
    case (state)
      INIT: begin
        {fd_clr, dx_clr, xm_clr, mw_clr} = '1;
        state_nx = RUN;
      end
      RUN: begin
        {pc_en, fd_en, dx_en, xm_en, mw_en} = '1;
        if (x_br_taken) begin
          fd_clr = 1'b1;
          dx_clr = 1'b1;
        end else begin
          if (lu) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_clr = 1'b1;
            stall = 1'b1;
          end
          if (x_md_op) begin
            md_start = 1'b1;
            state_nx = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        {xm_en, xm_clr, mw_en} = '1;
        stall = 1'b1;
        state_nx = (md_ready || busy_last) ? MD_DONE : MD_BUSY;
      end
      default: begin
        {xm_en, mw_en, md_sel} = '1;
        math_excep = exc_q | to_q;
        state_nx = RUN;
      end
    endcase
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= INIT;
      busy_cnt <= '0;
      exc_q <= 1'b0;
      to_q <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (state == MD_BUSY) begin
        busy_cnt <= busy_cnt + BW'(1);
        if (md_ready) exc_q <= md_excep;
        else if (busy_last) to_q <= 1'b1;
      end else if (state == MD_DONE) begin
        busy_cnt <= '0;
        exc_q <= 1'b0;
        to_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random stimulus, expected responses queued for a negedge monitor
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam int TO = 40;
  localparam int CW = 8;
  localparam int SMAX = (1 << CW) - 1;
  logic clk = 1'b0, clr_n = 1'b0;
  logic dx_is_load = 1'b0, fd_uses_rt = 1'b0, x_br_taken = 1'b0, x_md_op = 1'b0, md_ready = 1'b0, md_excep = 1'b0;
  logic [AW-1:0] dx_rd = '0, fd_rs = '0, fd_rt = '0;
  logic pc_en, fd_en, dx_en, xm_en, mw_en, fd_clr, dx_clr, xm_clr, mw_clr, md_start, md_sel, math_excep;
  logic [CW-1:0] stall_cycles;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_AW(AW), .MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .clr_n(clr_n), .dx_is_load(dx_is_load), .dx_rd(dx_rd), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rt(fd_uses_rt), .x_br_taken(x_br_taken), .x_md_op(x_md_op), .md_ready(md_ready),
    .md_excep(md_excep), .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_clr(fd_clr), .dx_clr(dx_clr), .xm_clr(xm_clr), .mw_clr(mw_clr), .md_start(md_start),
    .md_sel(md_sel), .math_excep(math_excep), .stall_cycles(stall_cycles)
  );
  typedef struct packed {
    logic rn, ld;
    logic [AW-1:0] rd, rs, rt;
    logic urt, br, md, rdy, exc;
  } stim_t;
  typedef struct packed {
    logic [11:0] ctl;
    logic [CW-1:0] st;
    int cyc;
  } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0, cyc = 0;
  // reference model: pending-flush flag, busy/done phases, elapsed busy cycles, stall total
  bit m_init = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_exc = 1'b0;
  int m_bcnt = 0, m_stall = 0;
  function automatic stim_t idle(bit rn = 1'b1);
    stim_t s = '0;
    s.rn = rn;
    return s;
  endfunction
  task automatic step(input stim_t s);
    exp_t e;
    bit lu, pc, fd, dx, xm, mw, cf, cd, cx, cm, st, sl, ex;
    @(posedge clk);
    #1;
    {clr_n, dx_is_load, dx_rd, fd_rs, fd_rt} = {s.rn, s.ld, s.rd, s.rs, s.rt};
    {fd_uses_rt, x_br_taken, x_md_op, md_ready, md_excep} = {s.urt, s.br, s.md, s.rdy, s.exc};
    lu = s.ld && s.rd != 0 && (s.rd == s.rs || (s.urt && s.rd == s.rt));
    {pc, fd, dx, xm, mw, cf, cd, cx, cm, st, sl, ex} = '0;
    if (!s.rn || m_init) {cf, cd, cx, cm} = 4'hF;
    else if (m_busy) {xm, mw, cx} = 3'b111;
    else if (m_done) {xm, mw, sl, ex} = {3'b111, m_exc};
    else begin
      {pc, fd, dx, xm, mw} = 5'h1F;
      if (s.br) {cf, cd} = 2'b11;
      else begin
        if (lu) {pc, fd, cd} = 3'b001;
        st = s.md;
      end
    end
    e.ctl = {pc, fd, dx, xm, mw, cf, cd, cx, cm, st, sl, ex};
    e.st = s.rn ? CW'(m_stall) : '0;
    e.cyc = cyc++;
    q.push_back(e);
    if (!s.rn) begin
      {m_init, m_busy, m_done, m_exc} = 4'b1000;
      m_bcnt = 0;
      m_stall = 0;
    end else if (m_init) m_init = 1'b0;
    else if (m_busy) begin
      m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
      m_bcnt++;
      if (s.rdy || m_bcnt == TO) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_exc = s.rdy ? s.exc : 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_exc = 1'b0;
      m_bcnt = 0;
    end else if (!s.br) begin
      if (lu) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
      if (s.md) m_busy = 1'b1;
    end
  endtask
  task automatic md_op();
    stim_t s = idle();
    s.md = 1'b1;
    step(s);
  endtask
  initial begin
    exp_t e;
    logic [11:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_clr, dx_clr, xm_clr, mw_clr, md_start, md_sel, math_excep};
        checks++;
        if (act === e.ctl) passed++;
        else $display("FAIL ctl cyc=%0d got=%b want=%b (pc fd dx xm mw fdc dxc xmc mwc start sel exc)", e.cyc, act, e.ctl);
        checks++;
        if (stall_cycles === e.st) passed++;
        else $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", e.cyc, stall_cycles, e.st);
      end
    end
  end
  initial begin
    stim_t s;
    repeat (3) step(idle(1'b0));
    repeat (3) step(idle());
    s = idle(); s.ld = 1'b1; s.rd = 5; s.rs = 5;
    step(s);
    s.rd = 0; s.rs = 0;
    step(s);
    s = idle(); s.ld = 1'b1; s.rd = 7; s.rt = 7; s.urt = 1'b1;
    step(s);
    s.urt = 1'b0;
    step(s);
    s = idle(); s.ld = 1'b1; s.rd = 5; s.rs = 5; s.br = 1'b1;
    step(s);
    s = idle(); s.br = 1'b1; s.md = 1'b1;
    step(s);
    step(idle());
    md_op();
    repeat (15) step(idle());
    s = idle(); s.rdy = 1'b1; s.exc = 1'b1;
    step(s);
    repeat (2) step(idle());
    md_op();
    repeat (15) step(idle());
    s.exc = 1'b0;
    step(s);
    s = idle(); s.rdy = 1'b1; s.br = 1'b1;
    repeat (2) step(s);
    md_op();
    repeat (TO + 3) step(idle());
    md_op();
    repeat (7) step(idle());
    step(idle(1'b0));
    repeat (3) step(idle());
    for (int i = 0; i < 7; i++) begin
      md_op();
      repeat (TO + 1) step(idle());
    end
    s = idle(); s.ld = 1'b1; s.rd = 3; s.rs = 3;
    repeat (3) step(s);
    step(idle());
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rn = $urandom_range(499) != 0;
      s.ld = $urandom_range(2) == 0;
      s.rd = AW'($urandom_range(3));
      s.rs = AW'($urandom_range(3));
      s.rt = AW'($urandom_range(3));
      s.urt = 1'($urandom);
      s.br = $urandom_range(7) == 0;
      s.md = $urandom_range(15) == 0;
      s.rdy = $urandom_range(9) == 0;
      s.exc = 1'($urandom);
      if (s.md) s.ld = 1'b0;
      step(s);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drain got=%0d want=0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
